// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a req/ready handshake with WAIT_STATES cycles of latency.
// Define DMEM_ERRCHK_EN to flag misaligned / out-of-range accesses on err and suppress their effects.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, next_state;
  logic [3:0] cnt, next_cnt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_err;
  logic                  enter_resp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_cnt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) next_state = RESP;
        else             next_cnt   = cnt - 4'd1;
      end
      RESP: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the access commits on the same edge that samples the request,
  // so the live inputs are used instead of the not-yet-latched copies.
  assign acc_we     = (state == IDLE) ? we    : we_q;
  assign acc_addr   = (state == IDLE) ? addr  : addr_q;
  assign acc_wdata  = (state == IDLE) ? wdata : wdata_q;
  assign acc_idx    = acc_addr[DEPTH_LOG2+1:2];
  assign enter_resp = (next_state == RESP) && (state != RESP);

`ifdef DMEM_ERRCHK_EN
  assign acc_err = (|acc_addr[1:0]) || (|acc_addr[31:DEPTH_LOG2+2]);
  assign err     = (state == RESP) && ((|addr_q[1:0]) || (|addr_q[31:DEPTH_LOG2+2]));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[31:DEPTH_LOG2+2], addr_q[1:0],
                              acc_addr[31:DEPTH_LOG2+2], acc_addr[1:0]};
  assign acc_err = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !acc_err)
      mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else if (enter_resp && !acc_we)
      rdata <= acc_err ? 32'h0 : mem[acc_idx];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance a uses 2 wait states, instance b uses 0.
// Expected responses are queued at issue time and checked by per-instance monitors on ready.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, err_a, err_b;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  bit   rsp_pending [2];

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .ready(ready_a), .err(err_a)
  );

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .ready(ready_b), .err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction

  task automatic drive(input int sel, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end else begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end
  endtask

  // Issues one request (starting at a negedge) and returns at the negedge where ready is seen,
  // leaving req high so a following call forms a back-to-back request.
  task automatic access(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_e, input bit drop);
    exp_t e;
    bit   seen;
    drive(sel, 1'b1, w, a, d);
    if (rsp_pending[sel]) @(posedge clk);
    @(posedge clk);
    e.rdata = exp_rd;
    e.err   = exp_e;
    e.cyc   = cyc + 1 + ((sel == 0) ? 2 : 0);
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (drop && i == 0) drive(sel, 1'b0, w, a, d);
      if (rdy(sel)) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout_%0d actual=0 required=1", sel);
    end
    rsp_pending[sel] = 1'b1;
  endtask

  task automatic idle(input int n);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (n) @(negedge clk);
    rsp_pending[0] = 1'b0;
    rsp_pending[1] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && ready_a) begin
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ready_a actual=1 required=0");
      end else begin
        ea = q_a.pop_front();
        chk("rdata_a", rdata_a, ea.rdata);
        chk("err_a", {31'b0, err_a}, {31'b0, ea.err});
        chk("latency_a", 32'(cyc), 32'(ea.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && ready_b) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ready_b actual=1 required=0");
      end else begin
        eb = q_b.pop_front();
        chk("rdata_b", rdata_b, eb.rdata);
        chk("err_b", {31'b0, err_b}, {31'b0, eb.err});
        chk("latency_b", 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  task automatic applyStimulus;
    // Back-to-back traffic on the zero-wait instance with req held high.
    access(1, 1'b1, 32'h0, 32'h0101_0101, 32'h0, 1'b0, 1'b0);
    access(1, 1'b1, 32'h4, 32'h0202_0202, 32'h0, 1'b0, 1'b0);
    access(1, 1'b0, 32'h0, 32'h0,         32'h0101_0101, 1'b0, 1'b0);
    access(1, 1'b0, 32'h4, 32'h0,         32'h0202_0202, 1'b0, 1'b0);
    idle(2);

    access(0, 1'b1, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    idle(1);
    access(0, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle(3);
    chk("rdata_hold", rdata_a, 32'hCAFE_F00D);

    access(0, 1'b1, 32'h14, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b1);
    idle(3);
    access(0, 1'b0, 32'h14, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
    idle(1);

    // Reset while a store sits in WAIT: it must vanish without a response or RAM write.
    access(0, 1'b1, 32'h20, 32'h1111_1111, 32'h1234_5678, 1'b0, 1'b0);
    idle(1);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'b0, ready_a}, 32'h0);
    chk("abort_rdata", rdata_a, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(4);
    access(0, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
    idle(1);

    access(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0, 1'b0);
    idle(1);
`ifdef DMEM_ERRCHK_EN
    access(0, 1'b1, 32'h12,  32'hBAD0_BAD0, 32'h1111_1111, 1'b1, 1'b0);
    idle(1);
    access(0, 1'b1, 32'h400, 32'h0BAD_F00D, 32'h1111_1111, 1'b1, 1'b0);
    idle(1);
    access(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1);
    access(0, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    idle(1);
    access(0, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);
`else
    access(0, 1'b1, 32'h400, 32'h0BAD_F00D, 32'h1111_1111, 1'b0, 1'b0);
    idle(1);
    access(0, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
`endif
    idle(5);
  endtask

  task automatic checkOutput;
    chk("pending_a", 32'(q_a.size()), 32'h0);
    chk("pending_b", 32'(q_b.size()), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ready_a", {31'b0, ready_a}, 32'h0);
    chk("reset_rdata_a", rdata_a, 32'h0);
    chk("reset_err_a",   {31'b0, err_a}, 32'h0);
    chk("reset_ready_b", {31'b0, ready_b}, 32'h0);
    chk("reset_rdata_b", rdata_b, 32'h0);
    reset = 1'b1;
    applyStimulus();
    checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
